vdp_port_ctrl: RTL and testbench
================================

# vdp_port_ctrl

CPU-facing port controller for the MSX video subsystem. It decodes Z80 accesses to the data port (0x98) and control port (0x99) into VRAM read and write cycles for the `video` block's CPU-side VRAM port. It holds registers R0–R7 and decodes them into the `video` configuration inputs. It also latches the status flags and generates `n_int`.

## Interface
- `VRAM_AW`, default 14: VRAM address width; the address counter wraps at 2^VRAM_AW.
- `clk`  in  1  clock (CPU clock domain; the same clock drives the `video` VRAM port A).
- `reset`  in  1  synchronous, active-high reset.
- `port_sel`  in  1  0 = data port, 1 = control port.
- `cpu_wr`  in  1  single-cycle write strobe.
- `cpu_rd`  in  1  single-cycle read strobe.
- `cpu_din`  in  8  CPU write data.
- `cpu_dout`  out  8  CPU read data, registered.
- `vram_addr`  out  VRAM_AW  VRAM address.
- `vram_wr`  out  1  VRAM write strobe, one cycle.
- `vram_rd`  out  1  VRAM read strobe, one cycle.
- `vram_dout`  out  8  VRAM write data.
- `vram_din`  in  8  VRAM read data, valid 1 cycle after `vram_rd`.
- `frame_pulse`  in  1  end-of-active-frame pulse from `video`.
- `sprite_collision`  in  1  collision indication from `video`.
- `too_many_sprites`  in  1  fifth-sprite indication from `video`.
- `sprite5`  in  5  fifth-sprite number from `video`.
- `mode`  out  2  0 = text, 1 = graphics 1, 2 = graphics 2, 3 = multicolour.
- `video_on`  out  1  R1[6].
- `sprite_large`  out  1  R1[1].
- `sprite_enlarged`  out  1  R1[0].
- `name_table_addr`  out  14  {R2[3:0], 10'b0}.
- `color_table_addr`  out  14  {R3, 6'b0}; in mode 2, {R3[7], 13'b0}.
- `font_addr`  out  14  {R4[2:0], 11'b0}; in mode 2, {R4[2], 13'b0}.
- `sprite_attr_addr`  out  14  {R5[6:0], 7'b0}.
- `sprite_pattern_table_addr`  out  14  {R6[2:0], 11'b0}.
- `text_color`  out  4  R7[7:4].
- `back_color`  out  4  R7[3:0].
- `n_int`  out  1  active-low interrupt, equal to !(F & R1[5]).

## Operation
- **Mode decode.** R1[4] (M1) selects mode 0. Otherwise R0[1] (M3) selects mode 2. Otherwise R1[3] (M2) selects mode 3. Otherwise mode is 1.
- **Control-port byte toggle.** The toggle has two states, FIRST and SECOND.
  - A control write in FIRST stores `cpu_din` into `latch` and moves to SECOND.
  - A control write in SECOND returns to FIRST and acts on `cpu_din[7:6]`:
    - `1x`: write R[`cpu_din[2:0]`] from `latch`.
    - `01`: set `addr` = {`cpu_din[5:0]`, `latch`}, write setup only, no VRAM cycle.
    - `00`: set `addr` the same way, then prefetch.
  - Any data-port access or status read forces the toggle to FIRST.
- **Prefetch.** Assert `vram_rd` with `vram_addr` = `addr`. On the next cycle capture `vram_din` into `rbuf`. `addr` increments when the read is issued.
- **Data write.** Assert `vram_wr` with `vram_addr` = `addr` and `vram_dout` = `cpu_din`. Set `rbuf` = `cpu_din`, then increment `addr`.
- **Data read.** `cpu_dout` <= `rbuf`, then prefetch.
- **Status read.** `cpu_dout` <= {F, 5S, C, `fifth`}. On the same cycle F, 5S and C clear.
- **Status flags.**
  - F sets on `frame_pulse`.
  - C sets on `sprite_collision`.
  - 5S sets on `too_many_sprites` while 5S = 0; `fifth` <= `sprite5` at that moment.
  - `fifth` is held until the next capture, not cleared by a status read.
- **Set/clear collision.** If a set event and a status-read clear occur in the same cycle, set wins and the flag stays 1 for the next read.
- **Address wrap.** `addr` wraps from 2^VRAM_AW−1 to 0.

## Timing
- **Reset values.**
  - All registers, `addr`, `latch`, `rbuf`, flags and `cpu_dout` reset to 0.
  - Toggle resets to FIRST; `vram_wr` = `vram_rd` = 0; `n_int` = 1.
  - Decoded outputs are therefore `mode` = 1, `video_on` = 0, all table addresses 0.
- **CPU strobe latency.** `vram_wr`/`vram_rd` assert in the cycle after the CPU strobe. `cpu_dout` is valid the cycle after `cpu_rd` and held until the next read.
- **Access spacing.** CPU strobes are at least 3 cycles apart, so a prefetch always completes before the next access; nothing is queued. `cpu_wr` and `cpu_rd` asserted together: write takes priority, read ignored.
- **Register write latency.** A register write is visible on the decoded outputs 1 cycle after the second control byte.
- **`n_int` latency.** `n_int` is registered and follows F/IE with 1 cycle of latency.
- **Reset during an access.** Reset mid-prefetch drops the capture and returns the toggle to FIRST.

## Structure
- Package `vdp_pkg` holds:
  - register index constants;
  - mode encodings MODE_TEXT, MODE_G1, MODE_G2, MODE_MC;
  - status bit positions;
  - table-address shift constants.
- Sub-module `vdp_regs`: R0–R7 storage plus the combinational mode and table-address decode.
- `vdp_port_ctrl` holds the toggle FSM, address counter, read-ahead buffer and status logic.

## Test plan
1. Control writes 0x00 then 0x40, then data writes 0xAA, 0xBB → VRAM writes 0xAA at 0x0000 and 0xBB at 0x0001; `addr` = 0x0002.
2. Control writes 0x01 then 0x00 → `vram_rd` at 0x0001. The next data read returns the byte stored at 0x0001; the following read returns the byte at 0x0002.
3. Control writes 0xF0 then 0x87 → `text_color` = 0xF, `back_color` = 0x0. Control writes 0x02 then 0x80 (R0 M3) → `mode` = 2, and `color_table_addr` follows R3[7].
4. Set R1 = 0x60, pulse `frame_pulse` → `n_int` = 0. Status read returns bit7 = 1, and `n_int` = 1 one cycle later. A `frame_pulse` on the read cycle → F remains 1.
5. Control write 0x12, then status read, then control writes 0x34, 0x40 → toggle reset, so `addr` = 0x0034 with write setup.
6. Write setup to 0x3FFF, two data writes → the second write lands at 0x0000.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared constants for the VDP port controller: register indices, display modes,
// status bit positions and table-address shifts.
package vdp_pkg;

  localparam logic [2:0] REG_MODE0  = 3'd0;
  localparam logic [2:0] REG_MODE1  = 3'd1;
  localparam logic [2:0] REG_NAME   = 3'd2;
  localparam logic [2:0] REG_COLOR  = 3'd3;
  localparam logic [2:0] REG_FONT   = 3'd4;
  localparam logic [2:0] REG_SATTR  = 3'd5;
  localparam logic [2:0] REG_SPAT   = 3'd6;
  localparam logic [2:0] REG_COLORS = 3'd7;

  typedef enum logic [1:0] {
    MODE_TEXT = 2'd0,
    MODE_G1   = 2'd1,
    MODE_G2   = 2'd2,
    MODE_MC   = 2'd3
  } vdp_mode_e;

  typedef enum logic {
    TogFirst,
    TogSecond
  } vdp_tog_e;

  localparam int unsigned STAT_F  = 7;
  localparam int unsigned STAT_5S = 6;
  localparam int unsigned STAT_C  = 5;

  localparam int unsigned SHIFT_NAME  = 10;
  localparam int unsigned SHIFT_COLOR = 6;
  localparam int unsigned SHIFT_FONT  = 11;
  localparam int unsigned SHIFT_SATTR = 7;
  localparam int unsigned SHIFT_SPAT  = 11;
  localparam int unsigned SHIFT_G2    = 13;

  function automatic logic [13:0] tbl_addr(input logic [7:0] field, input int unsigned shift);
    return 14'(field) << shift;
  endfunction

endpackage

// File: rtl/vdp_regs.sv
// VDP register file R0-R7 with combinational decode of display mode and
// VRAM table base addresses.
module vdp_regs
  import vdp_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr,
  input  logic [2:0]  i_idx,
  input  logic [7:0]  i_data,
  output logic [1:0]  o_mode,
  output logic        o_video_on,
  output logic        o_int_en,
  output logic        o_sprite_large,
  output logic        o_sprite_enlarged,
  output logic [13:0] o_name_table_addr,
  output logic [13:0] o_color_table_addr,
  output logic [13:0] o_font_addr,
  output logic [13:0] o_sprite_attr_addr,
  output logic [13:0] o_sprite_pattern_table_addr,
  output logic [3:0]  o_text_color,
  output logic [3:0]  o_back_color
);

  logic [7:0] r_regs [8];
  vdp_mode_e  w_mode;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (i_wr) begin
      r_regs[i_idx] <= i_data;
    end
  end

  // M1 (text) overrides M3, which overrides M2.
  always_comb begin
    w_mode = MODE_G1;
    if (r_regs[REG_MODE1][4]) begin
      w_mode = MODE_TEXT;
    end else if (r_regs[REG_MODE0][1]) begin
      w_mode = MODE_G2;
    end else if (r_regs[REG_MODE1][3]) begin
      w_mode = MODE_MC;
    end
  end

  always_comb begin
    o_mode                      = w_mode;
    o_video_on                  = r_regs[REG_MODE1][6];
    o_int_en                    = r_regs[REG_MODE1][5];
    o_sprite_large              = r_regs[REG_MODE1][1];
    o_sprite_enlarged           = r_regs[REG_MODE1][0];
    o_name_table_addr           = tbl_addr({4'b0, r_regs[REG_NAME][3:0]}, SHIFT_NAME);
    o_sprite_attr_addr          = tbl_addr({1'b0, r_regs[REG_SATTR][6:0]}, SHIFT_SATTR);
    o_sprite_pattern_table_addr = tbl_addr({5'b0, r_regs[REG_SPAT][2:0]}, SHIFT_SPAT);
    o_text_color                = r_regs[REG_COLORS][7:4];
    o_back_color                = r_regs[REG_COLORS][3:0];
    // Graphics 2 uses only the top bit of each table register (8 KiB aligned).
    if (w_mode == MODE_G2) begin
      o_color_table_addr = tbl_addr({7'b0, r_regs[REG_COLOR][7]}, SHIFT_G2);
      o_font_addr        = tbl_addr({7'b0, r_regs[REG_FONT][2]}, SHIFT_G2);
    end else begin
      o_color_table_addr = tbl_addr(r_regs[REG_COLOR], SHIFT_COLOR);
      o_font_addr        = tbl_addr({5'b0, r_regs[REG_FONT][2:0]}, SHIFT_FONT);
    end
  end

endmodule

// File: rtl/vdp_port_ctrl.sv
// Z80-facing VDP port controller: control-port byte toggle, VRAM address counter,
// read-ahead buffer, status flags and interrupt output.
module vdp_port_ctrl
  import vdp_pkg::*;
#(
  parameter int unsigned VRAM_AW = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               port_sel,
  input  logic               cpu_wr,
  input  logic               cpu_rd,
  input  logic [7:0]         cpu_din,
  output logic [7:0]         cpu_dout,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_wr,
  output logic               vram_rd,
  output logic [7:0]         vram_dout,
  input  logic [7:0]         vram_din,
  input  logic               frame_pulse,
  input  logic               sprite_collision,
  input  logic               too_many_sprites,
  input  logic [4:0]         sprite5,
  output logic [1:0]         mode,
  output logic               video_on,
  output logic               sprite_large,
  output logic               sprite_enlarged,
  output logic [13:0]        name_table_addr,
  output logic [13:0]        color_table_addr,
  output logic [13:0]        font_addr,
  output logic [13:0]        sprite_attr_addr,
  output logic [13:0]        sprite_pattern_table_addr,
  output logic [3:0]         text_color,
  output logic [3:0]         back_color,
  output logic               n_int
);

  vdp_tog_e           r_tog;
  logic [7:0]         r_latch;
  logic [VRAM_AW-1:0] r_addr;
  logic [7:0]         r_rbuf;
  logic               r_cap;
  logic [7:0]         r_cpu_dout;
  logic [VRAM_AW-1:0] r_vram_addr;
  logic               r_vram_wr;
  logic               r_vram_rd;
  logic [7:0]         r_vram_dout;
  logic               r_f;
  logic               r_5s;
  logic               r_c;
  logic [4:0]         r_fifth;
  logic               r_n_int;

  logic               w_data_wr;
  logic               w_data_rd;
  logic               w_ctl_wr;
  logic               w_stat_rd;
  logic               w_ctl_second;
  logic               w_reg_wr;
  logic               w_addr_set;
  logic               w_prefetch;
  logic [VRAM_AW-1:0] w_setup_addr;
  logic [VRAM_AW-1:0] w_addr_base;
  logic               w_5s_kept;
  logic               w_5s_set;
  logic               w_ie;
  logic [7:0]         w_status;

  // A simultaneous write wins; the read strobe is ignored.
  always_comb begin
    w_data_wr    = cpu_wr & ~port_sel;
    w_ctl_wr     = cpu_wr & port_sel;
    w_data_rd    = cpu_rd & ~cpu_wr & ~port_sel;
    w_stat_rd    = cpu_rd & ~cpu_wr & port_sel;
    w_ctl_second = w_ctl_wr & (r_tog == TogSecond);
    w_reg_wr     = w_ctl_second & cpu_din[7];
    w_addr_set   = w_ctl_second & ~cpu_din[7];
    w_prefetch   = w_data_rd | (w_addr_set & ~cpu_din[6]);
    w_setup_addr = VRAM_AW'({cpu_din[5:0], r_latch});
    w_addr_base  = w_addr_set ? w_setup_addr : r_addr;
    // A status read clears the flags, but a set arriving on that cycle survives.
    w_5s_kept    = r_5s & ~w_stat_rd;
    w_5s_set     = too_many_sprites & ~w_5s_kept;
    w_status           = 8'h00;
    w_status[STAT_F]   = r_f;
    w_status[STAT_5S]  = r_5s;
    w_status[STAT_C]   = r_c;
    w_status[4:0]      = r_fifth;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tog       <= TogFirst;
      r_latch     <= 8'h00;
      r_addr      <= '0;
      r_rbuf      <= 8'h00;
      r_cap       <= 1'b0;
      r_cpu_dout  <= 8'h00;
      r_vram_addr <= '0;
      r_vram_wr   <= 1'b0;
      r_vram_rd   <= 1'b0;
      r_vram_dout <= 8'h00;
      r_f         <= 1'b0;
      r_5s        <= 1'b0;
      r_c         <= 1'b0;
      r_fifth     <= 5'h00;
      r_n_int     <= 1'b1;
    end else begin
      r_vram_wr <= w_data_wr;
      r_vram_rd <= w_prefetch;
      r_cap     <= r_vram_rd;
      if (r_cap) begin
        r_rbuf <= vram_din;
      end

      if (w_data_wr || w_prefetch) begin
        r_vram_addr <= w_addr_base;
        r_addr      <= w_addr_base + VRAM_AW'(1);
      end else if (w_addr_set) begin
        r_addr <= w_setup_addr;
      end

      if (w_data_wr) begin
        r_vram_dout <= cpu_din;
        r_rbuf      <= cpu_din;
      end

      if (w_ctl_wr) begin
        if (r_tog == TogFirst) begin
          r_latch <= cpu_din;
          r_tog   <= TogSecond;
        end else begin
          r_tog <= TogFirst;
        end
      end else if (w_data_wr || w_data_rd || w_stat_rd) begin
        r_tog <= TogFirst;
      end

      if (w_data_rd) begin
        r_cpu_dout <= r_rbuf;
      end else if (w_stat_rd) begin
        r_cpu_dout <= w_status;
      end

      r_f  <= (r_f & ~w_stat_rd) | frame_pulse;
      r_c  <= (r_c & ~w_stat_rd) | sprite_collision;
      r_5s <= w_5s_kept | w_5s_set;
      if (w_5s_set) begin
        r_fifth <= sprite5;
      end

      r_n_int <= ~(r_f & w_ie);
    end
  end

  vdp_regs u_regs (
    .i_clk                       (clk),
    .i_reset                     (reset),
    .i_wr                        (w_reg_wr),
    .i_idx                       (cpu_din[2:0]),
    .i_data                      (r_latch),
    .o_mode                      (mode),
    .o_video_on                  (video_on),
    .o_int_en                    (w_ie),
    .o_sprite_large              (sprite_large),
    .o_sprite_enlarged           (sprite_enlarged),
    .o_name_table_addr           (name_table_addr),
    .o_color_table_addr          (color_table_addr),
    .o_font_addr                 (font_addr),
    .o_sprite_attr_addr          (sprite_attr_addr),
    .o_sprite_pattern_table_addr (sprite_pattern_table_addr),
    .o_text_color                (text_color),
    .o_back_color                (back_color)
  );

  assign cpu_dout  = r_cpu_dout;
  assign vram_addr = r_vram_addr;
  assign vram_wr   = r_vram_wr;
  assign vram_rd   = r_vram_rd;
  assign vram_dout = r_vram_dout;
  assign n_int     = r_n_int;

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Bench for vdp_port_ctrl: directed corner sequences, a register-decode vector
// table and a randomized run against a transaction-level port model.
module tb_vdp_port_ctrl;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          port_sel = 1'b0;
  logic          cpu_wr = 1'b0;
  logic          cpu_rd = 1'b0;
  logic [7:0]    cpu_din = 8'h00;
  logic [7:0]    cpu_dout;
  logic [AW-1:0] vram_addr;
  logic          vram_wr;
  logic          vram_rd;
  logic [7:0]    vram_dout;
  logic [7:0]    vram_din = 8'h00;
  logic          frame_pulse = 1'b0;
  logic          sprite_collision = 1'b0;
  logic          too_many_sprites = 1'b0;
  logic [4:0]    sprite5 = 5'h00;
  logic [1:0]    mode;
  logic          video_on;
  logic          sprite_large;
  logic          sprite_enlarged;
  logic [13:0]   name_table_addr;
  logic [13:0]   color_table_addr;
  logic [13:0]   font_addr;
  logic [13:0]   sprite_attr_addr;
  logic [13:0]   sprite_pattern_table_addr;
  logic [3:0]    text_color;
  logic [3:0]    back_color;
  logic          n_int;

  vdp_port_ctrl #(.VRAM_AW(AW)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .port_sel                  (port_sel),
    .cpu_wr                    (cpu_wr),
    .cpu_rd                    (cpu_rd),
    .cpu_din                   (cpu_din),
    .cpu_dout                  (cpu_dout),
    .vram_addr                 (vram_addr),
    .vram_wr                   (vram_wr),
    .vram_rd                   (vram_rd),
    .vram_dout                 (vram_dout),
    .vram_din                  (vram_din),
    .frame_pulse               (frame_pulse),
    .sprite_collision          (sprite_collision),
    .too_many_sprites          (too_many_sprites),
    .sprite5                   (sprite5),
    .mode                      (mode),
    .video_on                  (video_on),
    .sprite_large              (sprite_large),
    .sprite_enlarged           (sprite_enlarged),
    .name_table_addr           (name_table_addr),
    .color_table_addr          (color_table_addr),
    .font_addr                 (font_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .text_color                (text_color),
    .back_color                (back_color),
    .n_int                     (n_int)
  );

  always #5 clk = ~clk;

  // VRAM behaviour: synchronous write, read data one cycle after vram_rd.
  logic [7:0] mem [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  logic       init_req = 1'b0;
  int         init_seed = 0;

  function automatic logic [7:0] fill(input int i, input int seed);
    return 8'((i * 131 + seed * 7) ^ (i >> 3));
  endfunction

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= fill(i, init_seed);
    end else if (vram_wr) begin
      mem[vram_addr] <= vram_dout;
    end
    if (vram_rd) vram_din <= mem[vram_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Values sampled the cycle after a CPU strobe (s_nint2 one cycle later still).
  logic [7:0]    s_dout;
  logic          s_vwr, s_vrd, s_nint, s_nint2;
  logic [AW-1:0] s_vaddr;
  logic [7:0]    s_vdout;

  task automatic op(input logic ps, input logic wr, input logic rd, input logic [7:0] din,
                    input logic fp);
    @(negedge clk);
    port_sel = ps; cpu_wr = wr; cpu_rd = rd; cpu_din = din; frame_pulse = fp;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_rd = 1'b0; frame_pulse = 1'b0;
    s_dout = cpu_dout; s_vwr = vram_wr; s_vrd = vram_rd; s_vaddr = vram_addr;
    s_vdout = vram_dout; s_nint = n_int;
    @(negedge clk);
    s_nint2 = n_int;
    repeat (2) @(negedge clk);
  endtask

  task automatic ctl(input logic [7:0] d);
    op(1'b1, 1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [7:0] val);
    ctl(val);
    ctl({5'b10000, idx});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic reinit_mem(input int seed);
    @(negedge clk);
    init_seed = seed; init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill(i, seed);
  endtask

  task automatic pulse_flags(input logic f, input logic c, input logic t, input logic [4:0] s5);
    @(negedge clk);
    frame_pulse = f; sprite_collision = c; too_many_sprites = t; sprite5 = s5;
    @(negedge clk);
    frame_pulse = 1'b0; sprite_collision = 1'b0; too_many_sprites = 1'b0;
    @(negedge clk);
  endtask

  typedef enum int {SelMode, SelColor, SelFont, SelName, SelSattr, SelSpat, SelColors,
                    SelCtl} sel_e;
  typedef struct {
    logic [2:0]  idx;
    logic [7:0]  val;
    sel_e        sel;
    logic [13:0] exp;
  } vec_t;

  function automatic logic [13:0] get_sel(input sel_e s);
    case (s)
      SelMode:   return {12'b0, mode};
      SelColor:  return color_table_addr;
      SelFont:   return font_addr;
      SelName:   return name_table_addr;
      SelSattr:  return sprite_attr_addr;
      SelSpat:   return sprite_pattern_table_addr;
      SelColors: return {6'b0, text_color, back_color};
      default:   return {9'b0, mode, video_on, sprite_large, sprite_enlarged};
    endcase
  endfunction

  vec_t vecs[13];

  // Transaction-level model state for the randomized run.
  int         m_addr;
  bit         m_second;
  logic [7:0] m_latch, m_rbuf;

  initial begin
    vecs[0]  = '{3'd1, 8'h10, SelMode,   14'h0000};
    vecs[1]  = '{3'd1, 8'h08, SelMode,   14'h0003};
    vecs[2]  = '{3'd0, 8'h02, SelMode,   14'h0002};
    vecs[3]  = '{3'd3, 8'hFF, SelColor,  14'h2000};
    vecs[4]  = '{3'd4, 8'h07, SelFont,   14'h2000};
    vecs[5]  = '{3'd0, 8'h00, SelColor,  14'h3FC0};
    vecs[6]  = '{3'd4, 8'h05, SelFont,   14'h2800};
    vecs[7]  = '{3'd2, 8'h0F, SelName,   14'h3C00};
    vecs[8]  = '{3'd5, 8'h7F, SelSattr,  14'h3F80};
    vecs[9]  = '{3'd6, 8'h07, SelSpat,   14'h3800};
    vecs[10] = '{3'd7, 8'hF0, SelColors, 14'h00F0};
    vecs[11] = '{3'd1, 8'h43, SelCtl,    14'h000F};
    vecs[12] = '{3'd0, 8'h02, SelFont,   14'h2000};

    reinit_mem(1);
    do_reset();
    @(negedge clk);
    check("rst_mode", {30'b0, mode}, 32'd1);
    check("rst_nint_strobes", {29'b0, n_int, vram_wr, vram_rd}, 32'b100);
    check("rst_dout_video", {23'b0, cpu_dout, video_on}, 32'd0);
    check("rst_tables", {4'b0, name_table_addr, color_table_addr} | {18'b0, font_addr}
          | {18'b0, sprite_attr_addr} | {18'b0, sprite_pattern_table_addr}, 32'd0);

    // Write setup at 0 then sequential writes.
    ctl(8'h00); ctl(8'h40);
    op(1'b0, 1'b1, 1'b0, 8'hAA, 1'b0);
    check("t1_wr0", {8'b0, s_vwr, s_vrd, s_vaddr, s_vdout}, {8'b0, 2'b10, 14'h0000, 8'hAA});
    op(1'b0, 1'b1, 1'b0, 8'hBB, 1'b0);
    check("t1_wr1", {8'b0, s_vwr, s_vrd, s_vaddr, s_vdout}, {8'b0, 2'b10, 14'h0001, 8'hBB});
    op(1'b0, 1'b1, 1'b0, 8'hCC, 1'b0);
    check("t1_wr2", {8'b0, s_vwr, s_vaddr}, {8'b0, 1'b1, 14'h0002});

    // Read setup with prefetch, then two reads.
    ctl(8'h01); ctl(8'h00);
    check("t2_prefetch", {16'b0, s_vwr, s_vrd, s_vaddr}, {16'b0, 2'b01, 14'h0001});
    op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    check("t2_rd1", {24'b0, s_dout}, 32'hBB);
    check("t2_rd1_next", {16'b0, s_vrd, 1'b0, s_vaddr}, {16'b0, 2'b10, 14'h0002});
    op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    check("t2_rd2", {24'b0, s_dout}, 32'hCC);

    // Register writes through the raw control port.
    ctl(8'hF0); ctl(8'h87);
    check("t3_colors", {24'b0, text_color, back_color}, 32'hF0);
    ctl(8'h02); ctl(8'h80);
    check("t3_mode2", {30'b0, mode}, 32'd2);
    check("t3_color0", {18'b0, color_table_addr}, 32'h0);
    write_reg(3'd3, 8'h80);
    check("t3_color_g2", {18'b0, color_table_addr}, 32'h2000);

    // Frame interrupt and status read.
    write_reg(3'd1, 8'h60);
    check("t4_nint_idle", {31'b0, n_int}, 32'd1);
    pulse_flags(1'b1, 1'b0, 1'b0, 5'h00);
    check("t4_nint_low", {31'b0, n_int}, 32'd0);
    op(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    check("t4_stat_f", {31'b0, s_dout[7]}, 32'd1);
    check("t4_nint_after", {30'b0, s_nint, s_nint2}, 32'b01);
    op(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    check("t4_stat_clr", {31'b0, s_dout[7]}, 32'd0);
    op(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    check("t4_set_wins", {31'b0, s_dout[7]}, 32'd1);

    // Sprite flags.
    pulse_flags(1'b0, 1'b0, 1'b1, 5'h15);
    op(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    check("fl_5s", {24'b0, s_dout}, 32'h55);
    pulse_flags(1'b0, 1'b0, 1'b1, 5'h0A);
    op(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    check("fl_5s_recap", {24'b0, s_dout}, 32'h4A);
    op(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    check("fl_fifth_held", {24'b0, s_dout}, 32'h0A);
    pulse_flags(1'b0, 1'b1, 1'b0, 5'h1F);
    op(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    check("fl_coll", {24'b0, s_dout}, 32'h2A);

    // Status read resets the toggle.
    ctl(8'h12);
    op(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    ctl(8'h34); ctl(8'h40);
    op(1'b0, 1'b1, 1'b0, 8'h5A, 1'b0);
    check("t5_toggle", {18'b0, s_vaddr}, 32'h0034);

    // Address wrap.
    ctl(8'hFF); ctl(8'h7F);
    op(1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    check("t6_top", {18'b0, s_vaddr}, 32'h3FFF);
    op(1'b0, 1'b1, 1'b0, 8'h22, 1'b0);
    check("t6_wrap", {18'b0, s_vaddr}, 32'h0000);

    // Register decode table from a clean reset.
    do_reset();
    foreach (vecs[i]) begin
      write_reg(vecs[i].idx, vecs[i].val);
      check($sformatf("vec%0d", i), {18'b0, get_sel(vecs[i].sel)}, {18'b0, vecs[i].exp});
    end

    // Randomized port traffic against the model.
    do_reset();
    reinit_mem(7);
    m_addr = 0; m_second = 0; m_latch = 8'h00; m_rbuf = 8'h00;
    for (int n = 0; n < 400; n++) begin
      int k;
      logic [7:0] d;
      k = $urandom_range(0, 9);
      d = 8'($urandom);
      if (k <= 2) begin
        op(1'b0, 1'b1, 1'($urandom_range(0, 1)), d, 1'b0);
        check("rnd_wr", {8'b0, s_vwr, s_vrd, s_vaddr, s_vdout},
              {8'b0, 2'b10, 14'(m_addr), d});
        ref_mem[m_addr] = d;
        m_rbuf = d;
        m_addr = (m_addr + 1) % DEPTH;
        m_second = 0;
      end else if (k <= 5) begin
        op(1'b0, 1'b0, 1'b1, d, 1'b0);
        check("rnd_rd", {24'b0, s_dout}, {24'b0, m_rbuf});
        check("rnd_rd_cyc", {16'b0, s_vwr, s_vrd, s_vaddr}, {16'b0, 2'b01, 14'(m_addr)});
        m_rbuf = ref_mem[m_addr];
        m_addr = (m_addr + 1) % DEPTH;
        m_second = 0;
      end else if (k <= 8) begin
        ctl(d);
        if (!m_second) begin
          check("rnd_ctl1", {30'b0, s_vwr, s_vrd}, 32'd0);
          m_latch = d;
          m_second = 1;
        end else begin
          m_second = 0;
          if (d[7]) begin
            check("rnd_ctl_reg", {30'b0, s_vwr, s_vrd}, 32'd0);
          end else begin
            m_addr = int'(d[5:0]) * 256 + int'(m_latch);
            if (d[6]) begin
              check("rnd_ctl_wsetup", {30'b0, s_vwr, s_vrd}, 32'd0);
            end else begin
              check("rnd_ctl_prefetch", {16'b0, s_vwr, s_vrd, s_vaddr},
                    {16'b0, 2'b01, 14'(m_addr)});
              m_rbuf = ref_mem[m_addr];
              m_addr = (m_addr + 1) % DEPTH;
            end
          end
        end
      end else begin
        op(1'b1, 1'b0, 1'b1, d, 1'b0);
        check("rnd_stat", {24'b0, s_dout}, 32'h00);
        m_second = 0;
      end
    end
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
      check("rnd_mem", bad, 0);
    end

    // Reset while a prefetch is in flight.
    ctl(8'h00); ctl(8'h40);
    op(1'b0, 1'b1, 1'b0, 8'h77, 1'b0);
    ctl(8'h05);
    @(negedge clk);
    port_sel = 1'b0; cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    ctl(8'h00); ctl(8'h40);
    op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    check("rst_mid_rbuf", {24'b0, s_dout}, 32'h00);
    check("rst_mid_toggle", {18'b0, s_vaddr}, 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
